// File: rtl/tdm_mux.sv
// Registered N:1 data multiplexer with manual channel select and round-robin scan.
// Scan mode holds each channel for DWELL enabled cycles and marks the first sample of channel 0.
module tdm_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      en,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  output logic                      frame_start
);

  localparam logic [15:0]      DWELL_LAST = 16'(DWELL - 1);
  localparam logic [SEL_W-1:0] CH_LAST    = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] scan_ch_r;
  logic [15:0]      dwell_cnt_r;
  logic [WIDTH-1:0] sel_data_s;
  logic [WIDTH-1:0] scan_data_s;
  logic             sel_legal_s;

  // Channel data lookup for the manual select and the scan position; out-of-range indexes yield zero.
  always_comb begin
    sel_data_s  = '0;
    scan_data_s = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sel_data_s  = (32'(sel) == 32'(k))       ? in_data[k*WIDTH +: WIDTH] : sel_data_s;
      scan_data_s = (32'(scan_ch_r) == 32'(k)) ? in_data[k*WIDTH +: WIDTH] : scan_data_s;
    end
    sel_legal_s = (32'(sel) < 32'(CHANNELS));
  end

  // Output registers and scan position; reset wins over everything, en=0 freezes position.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data    <= '0;
      out_ch      <= '0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      scan_ch_r   <= '0;
      dwell_cnt_r <= 16'd0;
    end else if (!en) begin
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else if (!mode) begin
      // Manual mode parks the scan state so the next scan entry starts a fresh frame.
      scan_ch_r   <= '0;
      dwell_cnt_r <= 16'd0;
      frame_start <= 1'b0;
      if (sel_legal_s) begin
        out_data  <= sel_data_s;
        out_ch    <= sel;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else begin
      out_data    <= scan_data_s;
      out_ch      <= scan_ch_r;
      out_valid   <= 1'b1;
      frame_start <= (scan_ch_r == '0) && (dwell_cnt_r == 16'd0);
      if (dwell_cnt_r == DWELL_LAST) begin
        dwell_cnt_r <= 16'd0;
        if (scan_ch_r == CH_LAST) begin
          scan_ch_r <= '0;
        end else begin
          scan_ch_r <= scan_ch_r + SEL_W'(1);
        end
      end else begin
        dwell_cnt_r <= dwell_cnt_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_tdm_mux.sv
// Scoreboard bench for tdm_mux: expected outputs are queued as stimulus is driven
// and compared one cycle later against the registered outputs.
module tb_tdm_mux;

  localparam int W = 8;
  localparam int C = 6;
  localparam int S = 3;
  localparam int D = 2;

  logic             clk;
  logic             rst;
  logic [C*W-1:0]   in_data;
  logic [S-1:0]     sel;
  logic             mode;
  logic             en;
  logic [W-1:0]     out_data;
  logic [S-1:0]     out_ch;
  logic             out_valid;
  logic             frame_start;

  typedef struct {
    logic [W-1:0] d;
    logic [S-1:0] ch;
    logic         v;
    logic         fs;
  } exp_t;

  exp_t q[$];
  int   n_vec;
  int   n_err;
  int   scan_n;
  logic [W-1:0] m_d;
  logic [S-1:0] m_ch;

  tdm_mux #(.WIDTH(W), .CHANNELS(C), .SEL_W(S), .DWELL(D)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .mode(mode), .en(en),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, push the expected result, then pop and compare after the edge.
  task automatic step(input logic r, input logic m, input logic e, input logic [S-1:0] s);
    exp_t x;
    int   chn;
    rst = r; mode = m; en = e; sel = s;
    x.v  = 1'b0;
    x.fs = 1'b0;
    if (r) begin
      m_d = '0; m_ch = '0; scan_n = 0;
    end else if (!e) begin
      x.v = 1'b0;
    end else if (!m) begin
      scan_n = 0;
      if (int'(s) < C) begin
        m_d  = in_data[int'(s)*W +: W];
        m_ch = s;
        x.v  = 1'b1;
      end
    end else begin
      chn  = (scan_n / D) % C;
      m_ch = S'(chn);
      m_d  = in_data[chn*W +: W];
      x.fs = ((scan_n % (C*D)) == 0);
      x.v  = 1'b1;
      scan_n++;
    end
    x.d  = m_d;
    x.ch = m_ch;
    q.push_back(x);
    @(posedge clk);
    #1;
    x = q.pop_front();
    check("out_valid", 32'(out_valid), 32'(x.v));
    check("frame_start", 32'(frame_start), 32'(x.fs));
    check("out_ch", 32'(out_ch), 32'(x.ch));
    check("out_data", 32'(out_data), 32'(x.d));
  endtask

  initial begin
    n_vec = 0; n_err = 0; scan_n = 0;
    m_d = '0; m_ch = '0;
    rst = 1'b1; mode = 1'b1; en = 1'b1; sel = '0;
    for (int k = 0; k < C; k++) in_data[k*W +: W] = 8'hA0 + 8'(k);
    @(negedge clk);

    // 1: reset with scan enabled, then first scan sample
    step(1'b1, 1'b1, 1'b1, 3'd0);
    step(1'b1, 1'b1, 1'b1, 3'd0);
    step(1'b0, 1'b1, 1'b1, 3'd0);

    // 2: manual select 0..5, then illegal 6 and 7 hold A5
    for (int i = 0; i < C; i++) step(1'b0, 1'b0, 1'b1, S'(i));
    step(1'b0, 1'b0, 1'b1, 3'd6);
    step(1'b0, 1'b0, 1'b1, 3'd7);

    // 3: scan 14 cycles from a fresh frame
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b1, 3'd0);

    // 4: enable gap after first channel-2 sample
    step(1'b0, 1'b0, 1'b1, 3'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 3'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 3'd0);

    // 5: mode switching from channel 4 back through manual
    step(1'b0, 1'b0, 1'b1, 3'd0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1, 3'd0);
    step(1'b0, 1'b0, 1'b1, 3'd1);
    step(1'b0, 1'b1, 1'b1, 3'd0);
    step(1'b0, 1'b1, 1'b1, 3'd0);

    // 6: reset mid-scan at channel 3, count 1, then full restart
    step(1'b0, 1'b0, 1'b1, 3'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 3'd0);
    step(1'b1, 1'b1, 1'b1, 3'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 3'd0);

    // Random mix including data changes mid-dwell and disabled manual cycles
    for (int i = 0; i < 200; i++) begin
      if ((i % 7) == 3) in_data[$urandom_range(C-1)*W +: W] = 8'($urandom);
      step(($urandom_range(40) == 0), 1'($urandom), ($urandom_range(4) != 0), S'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tdm_mux.md
# tdm_mux

Parametrised, registered N:1 data multiplexer with two modes. In manual mode it selects a channel by index. In scan mode it time-division multiplexes all channels in a fixed round-robin order, holding each channel for a programmable dwell time. It sits where several same-width data sources share one downstream sink (display driver, serial framer, logger) and gives that sink registered data, the source channel index and a frame marker.

## Interface
Parameters:
- WIDTH, default 8: data bits per channel.
- CHANNELS, default 8: number of input channels, 2..256. Need not be a power of two.
- SEL_W, default 3: select/index width. Must satisfy 2^SEL_W >= CHANNELS.
- DWELL, default 4: enabled cycles spent on each channel in scan mode, 1..65535.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  CHANNELS*WIDTH  packed channel data. Channel k occupies bits [k*WIDTH +: WIDTH].
- sel  in  SEL_W  manual-mode channel select.
- mode  in  1  0 = manual, 1 = scan.
- en  in  1  advance/sample enable.
- out_data  out  WIDTH  registered selected data.
- out_ch  out  SEL_W  channel index that out_data came from.
- out_valid  out  1  out_data/out_ch updated this cycle with a legal channel.
- frame_start  out  1  one-cycle marker on the first scan sample of channel 0.

## Operation
- Internal state: scan_ch (SEL_W bits) and dwell_cnt (16 bits).
- Manual mode (mode=0), en=1:
  - If sel < CHANNELS: out_data <= channel sel, out_ch <= sel, out_valid <= 1.
  - If sel >= CHANNELS: out_valid <= 0, and out_data/out_ch hold.
  - scan_ch and dwell_cnt are forced to 0.
- Scan mode (mode=1), en=1:
  - out_data <= channel scan_ch, out_ch <= scan_ch, out_valid <= 1.
  - frame_start <= (scan_ch==0 && dwell_cnt==0).
  - If dwell_cnt == DWELL-1: dwell_cnt <= 0, and scan_ch <= scan_ch+1, or 0 when scan_ch == CHANNELS-1.
  - Otherwise dwell_cnt <= dwell_cnt+1.
- en=0 in either mode:
  - out_valid <= 0, frame_start <= 0.
  - out_data, out_ch, scan_ch and dwell_cnt hold.
- Entering scan from manual always starts at channel 0, count 0, because manual mode keeps the scan state at 0. The first scan sample asserts frame_start.
- Leaving scan mid-dwell discards scan position. The next manual sample is taken from sel.
- With DWELL=1, the channel advances on every enabled cycle.
- Changing sel or in_data mid-dwell is legal. Each sample uses the value present at that clock edge.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- No combinational path from any input to any output.
- Reset (rst=1 at an edge) sets:
  - out_data=0, out_ch=0, out_valid=0, frame_start=0.
  - scan_ch=0, dwell_cnt=0.
- rst has priority over en and mode. Reset mid-scan restarts at channel 0 on the first enabled scan cycle after rst falls, and that sample asserts frame_start.
- frame_start is high for exactly 1 cycle per scan frame, coincident with out_valid=1 and out_ch=0.
- A full scan frame spans CHANNELS*DWELL enabled cycles. Disabled cycles stretch the frame without losing position.

## Test plan
All scenarios use WIDTH=8, CHANNELS=6, SEL_W=3, DWELL=2, with channel k data = 8'hA0+k.
1. Reset: rst=1 for 2 cycles with en=1 and mode=1 -> all outputs 0. After rst falls, first output is out_ch=0, out_data=A0, frame_start=1.
2. Manual select: mode=0, en=1, sel=0..5 on consecutive cycles -> one cycle later, out_data=A0..A5, out_ch matches sel, out_valid=1. Then sel=6 or 7 -> out_valid=0 and out_data holds A5.
3. Scan sequence: mode=1, en=1 for 14 cycles -> out_ch sequence 0,0,1,1,2,2,3,3,4,4,5,5,0,0. frame_start=1 only on samples 1 and 13.
4. Enable gaps: in scan, drop en for 3 cycles after the first channel-2 sample -> out_valid=0 for those 3 cycles. On resume, the second channel-2 sample appears, then channel 3.
5. Mode switching: scan until out_ch=4, then mode=0 with sel=1 -> next out_data=A1. Return to mode=1 -> next sample out_ch=0 with frame_start=1.
6. Reset mid-scan at channel 3 with dwell_cnt=1 -> outputs cleared. Scan restarts at channel 0 with a full 2-cycle dwell.
